// File: rtl/sync_pkg.sv
// Shared types and constants for the toggle-based pulse crossing.
// The transmitter and any future receiver use these definitions.
package sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_bit_chain.sv
// Single-bit flop chain for bringing an asynchronous level into clk.
// Only stage 0 samples the asynchronous input.
module sync_bit_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) chain_reg[gi] <= 1'b0;
          else      chain_reg[gi] <= din;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (srst) chain_reg[gi] <= 1'b0;
          else      chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = chain_reg[STAGES-1];

endmodule

// File: rtl/sync_pulse_tx.sv
// Source side of an acknowledged toggle crossing: one outstanding toggle at a
// time, with further requests queued in a saturating pending counter.
module sync_pulse_tx
  import sync_pkg::*;
#(
  parameter int CNT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sCLK,
  input  logic                 sRST,
  input  logic                 sEN,
  input  logic                 dAckToggle,
  output logic                 sToggle,
  output logic                 sBusy,
  output logic                 sDone,
  output logic [CNT_WIDTH-1:0] sPending,
  output logic                 sOverflow
);

  // Shorter chains are not safe against metastability, so they are widened.
  localparam int CHAIN_STAGES =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] PEND_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  tx_state_t            state_reg;
  logic                 toggle_reg;
  logic [CNT_WIDTH-1:0] pending_reg;
  logic                 overflow_reg;
  logic                 ack_s;
  logic                 match;

  sync_bit_chain #(
    .STAGES(CHAIN_STAGES)
  ) u_ack_sync (
    .clk (sCLK),
    .srst(sRST),
    .din (dAckToggle),
    .dout(ack_s)
  );

  assign match = (ack_s == toggle_reg);

  always_ff @(posedge sCLK) begin
    if (sRST) begin
      state_reg    <= IDLE;
      toggle_reg   <= 1'b0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A request in IDLE launches directly and never touches the queue.
          if (sEN) begin
            toggle_reg <= ~toggle_reg;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          if (!match) begin
            if (sEN) begin
              if (pending_reg == PEND_MAX) overflow_reg <= 1'b1;
              else                         pending_reg  <= pending_reg + PEND_ONE;
            end
          end else if (pending_reg != '0) begin
            // Queue launches first; a coincident request takes its slot.
            toggle_reg <= ~toggle_reg;
            if (!sEN) pending_reg <= pending_reg - PEND_ONE;
          end else if (sEN) begin
            toggle_reg <= ~toggle_reg;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sToggle   = toggle_reg;
  assign sPending  = pending_reg;
  assign sOverflow = overflow_reg;
  assign sDone     = (state_reg == BUSY) && match;
  assign sBusy     = (state_reg == BUSY) || (pending_reg != '0);

endmodule

// File: tb/tb_sync_pulse_tx.sv
// Directed bench for sync_pulse_tx: a 2-bit-queue, 2-stage instance with a
// switchable ack source, and a 3-stage loopback instance for latency.
module tb_sync_pulse_tx;

  logic clk = 1'b0;
  logic srst;
  logic en;
  logic loopback;
  logic ack_force;

  logic       a_toggle, a_busy, a_done, a_overflow;
  logic [1:0] a_pending;
  logic       a_ack;

  logic       b_toggle, b_busy, b_done, b_overflow;
  logic [3:0] b_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign a_ack = loopback ? a_toggle : ack_force;

  sync_pulse_tx #(.CNT_WIDTH(2), .SYNC_STAGES(2)) dut_a (
    .sCLK      (clk),
    .sRST      (srst),
    .sEN       (en),
    .dAckToggle(a_ack),
    .sToggle   (a_toggle),
    .sBusy     (a_busy),
    .sDone     (a_done),
    .sPending  (a_pending),
    .sOverflow (a_overflow)
  );

  sync_pulse_tx #(.CNT_WIDTH(4), .SYNC_STAGES(3)) dut_b (
    .sCLK      (clk),
    .sRST      (srst),
    .sEN       (en),
    .dAckToggle(b_toggle),
    .sToggle   (b_toggle),
    .sBusy     (b_busy),
    .sDone     (b_done),
    .sPending  (b_pending),
    .sOverflow (b_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; en = 1'b0; loopback = 1'b1; ack_force = 1'b0;
    step();
    step();
    srst = 1'b0;
    n_checks++;
    if ({a_toggle, a_busy, a_done, a_pending, a_overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a: got tog=%b busy=%b done=%b pend=%0d ovf=%b, want all 0",
               a_toggle, a_busy, a_done, a_pending, a_overflow);
    end
    n_checks++;
    if ({b_toggle, b_busy, b_done, b_pending, b_overflow} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_b: got tog=%b busy=%b done=%b pend=%0d ovf=%b, want all 0",
               b_toggle, b_busy, b_done, b_pending, b_overflow);
    end
    $display("reset: outputs checked");
  endtask

  // Single pulse at cycle 0 on the S=2 instance, loopback.
  task automatic test_single(input string tag);
    logic e_tog  [0:5] = '{0, 1, 1, 1, 1, 1};
    logic e_done [0:5] = '{0, 0, 0, 1, 0, 0};
    logic e_busy [0:5] = '{0, 1, 1, 1, 0, 0};
    loopback = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      en = (c == 0);
      n_checks++;
      if (a_toggle !== e_tog[c] || a_done !== e_done[c] || a_busy !== e_busy[c] ||
          a_pending !== 2'd0) begin
        n_fail++;
        $display("FAIL %s c%0d: got tog=%b done=%b busy=%b pend=%0d, want tog=%b done=%b busy=%b pend=0",
                 tag, c, a_toggle, a_done, a_busy, a_pending, e_tog[c], e_done[c], e_busy[c]);
      end
      $display("%s c%0d: tog=%b done=%b busy=%b pend=%0d", tag, c, a_toggle, a_done, a_busy, a_pending);
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       e_tog  [0:10] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic       e_done [0:10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic       e_busy [0:10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [1:0] e_pend [0:10] = '{0, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
    loopback = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      en = (c <= 2);
      n_checks++;
      if (a_toggle !== e_tog[c] || a_done !== e_done[c] || a_busy !== e_busy[c] ||
          a_pending !== e_pend[c]) begin
        n_fail++;
        $display("FAIL b2b c%0d: got tog=%b done=%b busy=%b pend=%0d, want tog=%b done=%b busy=%b pend=%0d",
                 c, a_toggle, a_done, a_busy, a_pending, e_tog[c], e_done[c], e_busy[c], e_pend[c]);
      end
      $display("b2b c%0d: tog=%b done=%b busy=%b pend=%0d", c, a_toggle, a_done, a_busy, a_pending);
      step();
    end
    en = 1'b0;
  endtask

  // Ack stuck low, then released; overflow must stay sticky until reset.
  task automatic test_overflow_drain();
    logic [1:0] e_pend [0:5] = '{0, 0, 1, 2, 3, 3};
    logic       e_ovf  [0:5] = '{0, 0, 0, 0, 0, 1};
    int flips = 0;
    logic prev;
    loopback = 1'b0; ack_force = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      en = (c <= 4);
      n_checks++;
      if (a_pending !== e_pend[c] || a_overflow !== e_ovf[c] || a_toggle !== (c != 0)) begin
        n_fail++;
        $display("FAIL ovf c%0d: got pend=%0d ovf=%b tog=%b, want pend=%0d ovf=%b tog=%b",
                 c, a_pending, a_overflow, a_toggle, e_pend[c], e_ovf[c], (c != 0));
      end
      $display("ovf c%0d: pend=%0d ovf=%b tog=%b", c, a_pending, a_overflow, a_toggle);
      step();
    end
    en = 1'b0;
    loopback = 1'b1;
    prev = a_toggle;
    for (int c = 0; c < 20; c++) begin
      step();
      if (a_toggle !== prev) flips++;
      prev = a_toggle;
    end
    n_checks++;
    if (flips != 3 || a_pending !== 2'd0 || a_busy !== 1'b0 || a_overflow !== 1'b1 ||
        a_toggle !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got flips=%0d pend=%0d busy=%b ovf=%b tog=%b, want 3 0 0 1 0",
               flips, a_pending, a_busy, a_overflow, a_toggle);
    end
    $display("drain: flips=%0d pend=%0d ovf=%b", flips, a_pending, a_overflow);
    srst = 1'b1;
    step();
    srst = 1'b0;
    n_checks++;
    if ({a_toggle, a_busy, a_done, a_pending, a_overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL drain_reset: got tog=%b busy=%b done=%b pend=%0d ovf=%b, want all 0",
               a_toggle, a_busy, a_done, a_pending, a_overflow);
    end
    $display("drain_reset: ovf=%b pend=%0d", a_overflow, a_pending);
  endtask

  // Request coinciding with sDone while one event is queued.
  task automatic test_en_on_done();
    int flips = 0;
    logic prev;
    loopback = 1'b1;
    prev = a_toggle;
    for (int c = 0; c <= 12; c++) begin
      en = (c <= 1) || (c == 3);
      if (c == 3) begin
        n_checks++;
        if (a_done !== 1'b1 || a_pending !== 2'd1) begin
          n_fail++;
          $display("FAIL en_on_done c3: got done=%b pend=%0d, want 1 1", a_done, a_pending);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (a_pending !== 2'd1 || a_toggle !== 1'b0) begin
          n_fail++;
          $display("FAIL en_on_done c4: got pend=%0d tog=%b, want 1 0", a_pending, a_toggle);
        end
      end
      if (a_toggle !== prev) flips++;
      prev = a_toggle;
      $display("en_on_done c%0d: tog=%b done=%b pend=%0d", c, a_toggle, a_done, a_pending);
      step();
    end
    en = 1'b0;
    n_checks++;
    if (flips != 3 || a_overflow !== 1'b0 || a_busy !== 1'b0 || a_toggle !== 1'b1) begin
      n_fail++;
      $display("FAIL en_on_done end: got flips=%0d ovf=%b busy=%b tog=%b, want 3 0 0 1",
               flips, a_overflow, a_busy, a_toggle);
    end
  endtask

  task automatic test_reset_busy();
    loopback = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      en = 1'b1;
      step();
    end
    en = 1'b0;
    n_checks++;
    if (a_pending !== 2'd2 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy pre: got pend=%0d busy=%b, want 2 1", a_pending, a_busy);
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    n_checks++;
    if (a_toggle !== 1'b0 || a_pending !== 2'd0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy post: got tog=%b pend=%0d busy=%b, want 0 0 0",
               a_toggle, a_pending, a_busy);
    end
    $display("rst_busy: tog=%b pend=%0d busy=%b", a_toggle, a_pending, a_busy);
  endtask

  task automatic test_stages3();
    logic e_tog  [0:6] = '{0, 1, 1, 1, 1, 1, 1};
    logic e_done [0:6] = '{0, 0, 0, 0, 1, 0, 0};
    logic e_busy [0:6] = '{0, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c <= 6; c++) begin
      en = (c == 0);
      n_checks++;
      if (b_toggle !== e_tog[c] || b_done !== e_done[c] || b_busy !== e_busy[c] ||
          b_pending !== 4'd0) begin
        n_fail++;
        $display("FAIL s3 c%0d: got tog=%b done=%b busy=%b pend=%0d, want tog=%b done=%b busy=%b pend=0",
                 c, b_toggle, b_done, b_busy, b_pending, e_tog[c], e_done[c], e_busy[c]);
      end
      $display("s3 c%0d: tog=%b done=%b busy=%b", c, b_toggle, b_done, b_busy);
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_reset();
    test_back_to_back();
    test_reset();
    test_overflow_drain();
    test_reset();
    test_en_on_done();
    test_reset();
    test_reset_busy();
    test_single("after_rst");
    test_reset();
    test_stages3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
